// File: rtl/mips_out_capture_if.sv
// Bundle of the observed processor outputs, the capture controls and the
// host read port for mips_out_capture.
interface mips_out_capture_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4,
    parameter int CNT_W  = 16
);
    logic [DATA_W-1:0] mipsOut;
    logic              overflow;
    logic              capture_en;
    logic              clr_stats;
    logic              rd_ready;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic              rd_ovf;
    logic [ADDR_W:0]   level;
    logic [CNT_W-1:0]  dropped;
    logic              sticky_ovf;

    // Host / bench side: drives the observed bus and controls, reads the FIFO.
    modport master (
        output mipsOut, overflow, capture_en, clr_stats, rd_ready,
        input  rd_valid, rd_data, rd_ovf, level, dropped, sticky_ovf
    );

    // Capture block side.
    modport slave (
        input  mipsOut, overflow, capture_en, clr_stats, rd_ready,
        output rd_valid, rd_data, rd_ovf, level, dropped, sticky_ovf
    );
endinterface

// File: rtl/mips_out_capture.sv
// Change-capture consumer for the processor outputs: records every change of
// {overflow, mipsOut} into a FIFO and presents it on a FWFT valid/ready port.
//
//  state | meaning
//  IDLE  | capture disabled; next enabled cycle pushes unconditionally
//  RUN   | capture enabled; push on value change or rising overflow
module mips_out_capture #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4,
    parameter int CNT_W  = 16
) (
    input logic                clk,
    input logic                rst,
    mips_out_capture_if.slave  bus
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] FULL_LEVEL = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] ONE_LEVEL  = {{ADDR_W{1'b0}}, 1'b1};

    typedef enum logic {IDLE, RUN} state_t;

    state_t            state, state_next;
    logic [DATA_W-1:0] prev_out;
    logic              prev_ovf;
    logic [DATA_W:0]   mem [DEPTH];
    logic [ADDR_W-1:0] rd_ptr, wr_ptr, rd_ptr_inc;
    logic [ADDR_W:0]   level_q;
    logic [DATA_W-1:0] head_data;
    logic              head_ovf;
    logic [CNT_W-1:0]  dropped_q;
    logic              sticky_q;
    logic              push_req, pop, empty, full, push_ok, drop;

    assign empty      = (level_q == '0);
    assign full       = (level_q == FULL_LEVEL);
    // Pop depends only on registered state, so a push into an empty FIFO is never popped the same cycle.
    assign pop        = !empty && bus.rd_ready;
    assign push_ok    = push_req && (!full || pop);
    assign drop       = push_req && full && !pop;
    assign rd_ptr_inc = rd_ptr + 1'b1;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state and push request.
    always_comb begin
        state_next = state;
        push_req   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.capture_en) begin
                    push_req   = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (!bus.capture_en) begin
                    state_next = IDLE;
                end else if ((bus.mipsOut != prev_out) || (bus.overflow && !prev_ovf)) begin
                    push_req = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Previous-sample registers follow the bus only while capturing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_out <= '0;
            prev_ovf <= 1'b0;
        end else if (bus.capture_en) begin
            prev_out <= bus.mipsOut;
            prev_ovf <= bus.overflow;
        end
    end

    // Storage array; never read while its slot is invalid, so it needs no reset.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= {bus.overflow, bus.mipsOut};
    end

    // Pointers and occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            level_q <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr_inc;
            case ({push_ok, pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

    // Head register mirrors mem[rd_ptr]; it holds the last popped entry once empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_data <= '0;
            head_ovf  <= 1'b0;
        end else if (push_ok && (empty || (pop && level_q == ONE_LEVEL))) begin
            head_data <= bus.mipsOut;
            head_ovf  <= bus.overflow;
        end else if (pop && level_q != ONE_LEVEL) begin
            {head_ovf, head_data} <= mem[rd_ptr_inc];
        end
    end

    // Drop counter (saturating) and sticky overflow; a new event beats a clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dropped_q <= '0;
            sticky_q  <= 1'b0;
        end else begin
            if (bus.clr_stats)
                dropped_q <= {{(CNT_W-1){1'b0}}, drop};
            else if (drop && dropped_q != '1)
                dropped_q <= dropped_q + 1'b1;

            if (bus.capture_en && bus.overflow) sticky_q <= 1'b1;
            else if (bus.clr_stats)             sticky_q <= 1'b0;
        end
    end

    assign bus.rd_valid   = !empty;
    assign bus.rd_data    = head_data;
    assign bus.rd_ovf     = head_ovf;
    assign bus.level      = level_q;
    assign bus.dropped    = dropped_q;
    assign bus.sticky_ovf = sticky_q;
endmodule

// File: tb/tb_mips_out_capture.sv
// Bench for mips_out_capture: directed scenarios plus random traffic, all
// compared every cycle against a queue-based model of the capture rules.
module tb_mips_out_capture;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    mips_out_capture_if #(.DATA_W(32), .ADDR_W(4), .CNT_W(16)) bus ();

    mips_out_capture #(.DATA_W(32), .ADDR_W(4), .CNT_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Model state
    logic [32:0] q[$];
    logic [32:0] m_last;
    bit          m_run;
    logic [31:0] m_prev;
    bit          m_prev_ovf;
    logic [15:0] m_dropped;
    bit          m_sticky;

    task automatic model_reset();
        q.delete();
        m_last     = '0;
        m_run      = 0;
        m_prev     = '0;
        m_prev_ovf = 0;
        m_dropped  = '0;
        m_sticky   = 0;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        logic [32:0] head;
        head = (q.size() != 0) ? q[0] : m_last;
        check("rd_valid",   64'(bus.rd_valid),   64'(q.size() != 0));
        check("level",      64'(bus.level),      64'(q.size()));
        check("rd_data",    64'(bus.rd_data),    64'(head[31:0]));
        check("rd_ovf",     64'(bus.rd_ovf),     64'(head[32]));
        check("dropped",    64'(bus.dropped),    64'(m_dropped));
        check("sticky_ovf", 64'(bus.sticky_ovf), 64'(m_sticky));
    endtask

    // One clock: drive inputs, advance the model, compare just after the edge.
    task automatic cyc(input bit cap, input logic [31:0] d, input bit o, input bit clr, input bit rdy);
        bit pop, want, drop;
        bus.capture_en = cap;
        bus.mipsOut    = d;
        bus.overflow   = o;
        bus.clr_stats  = clr;
        bus.rd_ready   = rdy;

        pop  = (q.size() != 0) && rdy;
        want = cap && (!m_run || d != m_prev || (o && !m_prev_ovf));
        drop = 0;
        if (pop) m_last = q.pop_front();
        if (want) begin
            if (q.size() < 16) q.push_back({o, d});
            else               drop = 1;
        end
        if (clr)                               m_dropped = drop ? 16'd1 : 16'd0;
        else if (drop && m_dropped != 16'hFFFF) m_dropped = m_dropped + 16'd1;
        if (cap && o)  m_sticky = 1;
        else if (clr)  m_sticky = 0;
        m_run = cap;
        if (cap) begin
            m_prev     = d;
            m_prev_ovf = o;
        end

        @(posedge clk);
        #1;
        compare_all();
    endtask

    initial begin
        bus.capture_en = 0;
        bus.mipsOut    = '0;
        bus.overflow   = 0;
        bus.clr_stats  = 0;
        bus.rd_ready   = 0;
        model_reset();

        #12;
        check("reset_level",  64'(bus.level),    64'd0);
        check("reset_valid",  64'(bus.rd_valid), 64'd0);
        check("reset_data",   64'(bus.rd_data),  64'd0);
        check("reset_sticky", 64'(bus.sticky_ovf), 64'd0);
        rst = 0;

        // Change capture: 5,5,7,7,7,9
        cyc(1, 5, 0, 0, 0); cyc(1, 5, 0, 0, 0); cyc(1, 7, 0, 0, 0);
        cyc(1, 7, 0, 0, 0); cyc(1, 7, 0, 0, 0); cyc(1, 9, 0, 0, 0);
        check("t2_level", 64'(bus.level), 64'd3);
        check("t2_head0", 64'(bus.rd_data), 64'd5);
        cyc(0, 9, 0, 0, 1);
        check("t2_head1", 64'(bus.rd_data), 64'd7);
        cyc(0, 9, 0, 0, 1);
        check("t2_head2", 64'(bus.rd_data), 64'd9);
        cyc(0, 9, 0, 0, 1);
        check("t2_empty",     64'(bus.rd_valid), 64'd0);
        check("t2_hold_data", 64'(bus.rd_data),  64'd9);

        // Full and drop: 20 distinct values
        for (int i = 0; i < 20; i++) cyc(1, 32'(100 + i), 0, 0, 0);
        check("t3_level",   64'(bus.level),   64'd16);
        check("t3_dropped", 64'(bus.dropped), 64'd4);
        check("t3_head",    64'(bus.rd_data), 64'd100);

        // Push with pop while full
        cyc(1, 500, 0, 0, 1);
        check("t4_level",   64'(bus.level),   64'd16);
        check("t4_dropped", 64'(bus.dropped), 64'd4);
        check("t4_head",    64'(bus.rd_data), 64'd101);

        // Clear together with a drop leaves dropped at 1
        cyc(1, 600, 0, 1, 0);
        check("clr_drop", 64'(bus.dropped), 64'd1);

        for (int i = 0; i < 16; i++) cyc(0, 600, 0, 0, 1);
        check("t4_drained", 64'(bus.rd_valid), 64'd0);
        check("t4_tail",    64'(bus.rd_data),  64'd500);

        // Overflow flags
        cyc(1, 32'h7FFF_FFFF, 0, 0, 0);
        cyc(1, 32'h7FFF_FFFF, 1, 0, 0);
        cyc(1, 32'h7FFF_FFFF, 1, 0, 0);
        cyc(1, 32'h7FFF_FFFF, 0, 0, 0);
        check("t5_level",  64'(bus.level),      64'd2);
        check("t5_sticky", 64'(bus.sticky_ovf), 64'd1);
        cyc(1, 32'h7FFF_FFFF, 0, 1, 0);
        check("t5_clr",    64'(bus.sticky_ovf), 64'd0);
        cyc(1, 32'h7FFF_FFFF, 1, 1, 0);
        check("t5_setwin", 64'(bus.sticky_ovf), 64'd1);
        check("t5_level3", 64'(bus.level),      64'd3);
        check("t5_ovf0",   64'(bus.rd_ovf),     64'd0);
        cyc(0, 0, 0, 0, 1);
        check("t5_ovf1",   64'(bus.rd_ovf),     64'd1);
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 1);

        // Enable gating
        cyc(1, 42, 0, 0, 0);
        for (int i = 0; i < 10; i++) cyc(0, 32'(1000 + i), 0, 0, 0);
        check("t6_nopush", 64'(bus.level), 64'd1);
        cyc(1, 42, 0, 0, 0);
        check("t6_reenable", 64'(bus.level), 64'd2);
        cyc(1, 42, 0, 0, 0);
        check("t6_same", 64'(bus.level), 64'd2);
        cyc(1, 43, 0, 0, 0);
        check("t6_change", 64'(bus.level), 64'd3);

        // Asynchronous reset between edges with entries stored
        #2 rst = 1;
        #1;
        check("t1_level",   64'(bus.level),      64'd0);
        check("t1_valid",   64'(bus.rd_valid),   64'd0);
        check("t1_data",    64'(bus.rd_data),    64'd0);
        check("t1_ovf",     64'(bus.rd_ovf),     64'd0);
        check("t1_dropped", 64'(bus.dropped),    64'd0);
        check("t1_sticky",  64'(bus.sticky_ovf), 64'd0);
        model_reset();
        #2 rst = 0;

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            cyc(($urandom_range(0, 9) < 8),
                32'($urandom_range(0, 3)),
                ($urandom_range(0, 4) == 0),
                ($urandom_range(0, 19) == 0),
                ($urandom_range(0, 9) < 4));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
